// File: rtl/led_pattern_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pattern_gen_if
// Description : Button/pause inputs and LED/mode/tick outputs of led_pattern_gen.
// Revision    : 1.0  initial release
// ============================================================================
interface led_pattern_gen_if #(
    parameter int LED_W = 6
);
    logic             mode_btn_n;
    logic             pause;
    logic [LED_W-1:0] led;
    logic [1:0]       mode;
    logic             step_tick;

    modport master (
        output mode_btn_n,
        output pause,
        input  led,
        input  mode,
        input  step_tick
    );

    modport slave (
        input  mode_btn_n,
        input  pause,
        output led,
        output mode,
        output step_tick
    );
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pattern_gen
// Description : Four-mode LED pattern engine with debounced mode button and
//               pause. Optional PWM dimming of lit LEDs via `define LED_DIM_EN.
// Revision    : 1.0  initial release
// ============================================================================
module led_pattern_gen #(
    parameter int LED_W       = 6,
    parameter int CLK_HZ      = 27_000_000,
    parameter int STEP_MS     = 500,
    parameter int DEBOUNCE_MS = 20,
    parameter int ACTIVE_LOW  = 1,
    parameter int DIM_LEVEL   = 8
) (
    input  wire              sys_clk,
    input  wire              sys_rst_n,
    led_pattern_gen_if.slave bus
);
    localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int DB_W     = $clog2(DB_CYC + 1);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [LED_W-1:0]  SEED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0]  LED_RST   = (ACTIVE_LOW != 0) ? ~SEED_ONE : SEED_ONE;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    if (LED_W < 2 || LED_W > 32) begin : g_bad_led_w
        $error("led_pattern_gen: LED_W must be 2..32");
    end
    if (STEP_CYC < 2 || DB_CYC < 1) begin : g_bad_timing
        $error("led_pattern_gen: STEP_CYC must be >= 2 and DB_CYC >= 1");
    end
    if (DIM_LEVEL < 0 || DIM_LEVEL > 16) begin : g_bad_dim
        $error("led_pattern_gen: DIM_LEVEL must be 0..16");
    end

    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              db_state_q, db_state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_tick_q, step_tick_d;
    logic [LED_W-1:0]  pat_q, pat_d;
    logic              dir_q, dir_d;          // 0 = moving toward MSB
    mode_t             mode_q, mode_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              press;
    logic              step_wrap;
    logic              lit_en;
`ifdef LED_DIM_EN
    logic [3:0]        pwm_q, pwm_d;
`endif

    always_comb begin
        sync1_d    = bus.mode_btn_n;
        sync2_d    = sync1_q;
        db_state_d = db_state_q;
        db_cnt_d   = '0;
        press      = 1'b0;
        // Stable state flips only after DB_CYC consecutive disagreeing samples.
        if (sync2_q != db_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_state_d = sync2_q;
                press      = db_state_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        step_wrap   = !bus.pause && (step_cnt_q == STEP_LAST);
        step_tick_d = step_wrap;
        step_cnt_d  = step_cnt_q;
        if (!bus.pause) begin
            step_cnt_d = step_wrap ? '0 : step_cnt_q + 1'b1;
        end

        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        // A press outranks a coincident step: the new mode starts from its seed.
        if (press) begin
            mode_d     = mode_t'(mode_q + 2'd1);
            pat_d      = (mode_d == MODE_COUNT) ? '0 : SEED_ONE;
            dir_d      = 1'b0;
            step_cnt_d = '0;
        end else if (step_wrap) begin
            case (mode_q)
                MODE_ROT_L: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                MODE_ROT_R: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        pat_d = pat_q << 1;
                        if (pat_d[LED_W-1]) dir_d = 1'b1;
                    end else begin
                        pat_d = pat_q >> 1;
                        if (pat_d[0]) dir_d = 1'b0;
                    end
                end
                default: pat_d = pat_q + 1'b1;
            endcase
        end

`ifdef LED_DIM_EN
        pwm_d  = pwm_q + 4'd1;
        lit_en = ({1'b0, pwm_d} < 5'(DIM_LEVEL));
`else
        lit_en = 1'b1;
`endif
        // LED register tracks the next pattern so the pins change with pat.
        led_d = pat_d & {LED_W{lit_en}};
        if (ACTIVE_LOW != 0) led_d = ~led_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            db_state_q  <= 1'b1;
            db_cnt_q    <= '0;
            step_cnt_q  <= '0;
            step_tick_q <= 1'b0;
            pat_q       <= SEED_ONE;
            dir_q       <= 1'b0;
            mode_q      <= MODE_ROT_L;
            led_q       <= LED_RST;
`ifdef LED_DIM_EN
            pwm_q       <= 4'd0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_state_q  <= db_state_d;
            db_cnt_q    <= db_cnt_d;
            step_cnt_q  <= step_cnt_d;
            step_tick_q <= step_tick_d;
            pat_q       <= pat_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
`ifdef LED_DIM_EN
            pwm_q       <= pwm_d;
`endif
        end
    end

    assign bus.led       = led_q;
    assign bus.mode      = mode_q;
    assign bus.step_tick = step_tick_q;
endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Scoreboard bench for led_pattern_gen (LED_W=6, STEP_CYC=4, DB_CYC=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_pattern_gen;
    localparam int LED_W = 6;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    led_pattern_gen_if #(.LED_W(LED_W)) bus ();

    led_pattern_gen #(
        .LED_W      (LED_W),
        .CLK_HZ     (1000),
        .STEP_MS    (4),
        .DEBOUNCE_MS(2),
        .ACTIVE_LOW (1),
        .DIM_LEVEL  (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_assert  = 0;
    int         n_fail    = 0;
    int         exp_gap   = 0;
    int         cyc_no    = 0;
    int         last_tick = 0;
    logic [5:0] exp_q[$];

    logic [5:0] m_pat;
    logic [1:0] m_mode;
    int         m_bidx;
    bit         m_bdir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] led_of(input logic [5:0] p);
        return ~p;
    endfunction

    // Every step_tick consumes one expected LED value.
    initial begin
        forever begin
            @(negedge sys_clk);
            cyc_no++;
            if (sys_rst_n === 1'b1 && bus.step_tick === 1'b1) begin
                chk("tick_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("led_on_tick", bus.led, exp_q.pop_front());
                if (exp_gap != 0) chk("tick_period", cyc_no - last_tick, exp_gap);
                last_tick = cyc_no;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_pat  = 6'd1;
        m_mode = 2'd0;
        m_bidx = 0;
        m_bdir = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_steps(input int n);
        for (int i = 0; i < n; i++) begin
            case (m_mode)
                2'd0: m_pat = {m_pat[4:0], m_pat[5]};
                2'd1: m_pat = {m_pat[0], m_pat[5:1]};
                2'd2: begin
                    if (!m_bdir) begin
                        m_bidx++;
                        if (m_bidx == 5) m_bdir = 1'b1;
                    end else begin
                        m_bidx--;
                        if (m_bidx == 0) m_bdir = 1'b0;
                    end
                    m_pat = 6'(1 << m_bidx);
                end
                default: m_pat = m_pat + 6'd1;
            endcase
            exp_q.push_back(led_of(m_pat));
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cyc(1);
            k++;
        end
        chk("pending_ticks", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Must be called right after a step tick, so the press lands on a wrap.
    task automatic press(input bit rel);
        logic [1:0] old_mode;
        old_mode = m_mode;
        m_mode   = m_mode + 2'd1;
        m_pat    = (m_mode == 2'd3) ? 6'd0 : 6'd1;
        m_bidx   = 0;
        m_bdir   = 1'b0;
        exp_q.push_back(led_of(m_pat));
        bus.mode_btn_n = 1'b0;
        cyc(3);
        chk("mode_before_latency", bus.mode, old_mode);
        cyc(1);
        chk("mode_after_press", bus.mode, m_mode);
        chk("led_seed_on_press", bus.led, led_of(m_pat));
        chk("tick_on_press_wrap", bus.step_tick, 1'b1);
        if (rel) bus.mode_btn_n = 1'b1;
    endtask

    initial begin
        bus.mode_btn_n = 1'b1;
        bus.pause      = 1'b0;
        sys_rst_n      = 1'b0;
        model_reset();
        cyc(2);
        chk("reset_led", bus.led, 6'b111110);
        chk("reset_mode", bus.mode, 2'd0);
        chk("reset_tick", bus.step_tick, 1'b0);
        sys_rst_n = 1'b1;

        // Rotate left, one step every 4 cycles, back to start after 6 steps.
        exp_gap = 0;
        push_steps(1);
        drain(10);
        exp_gap = 4;
        push_steps(5);
        drain(30);
        chk("rotl_full_turn", bus.led, 6'b111110);

        // Held press -> mode 1 (rotate right); release is not an event.
        press(1'b0);
        push_steps(2);
        drain(12);
        bus.mode_btn_n = 1'b1;
        push_steps(2);
        drain(12);
        chk("release_no_event", bus.mode, 2'd1);

        // Bounce sweep, then asynchronous reset mid-sweep.
        press(1'b1);
        push_steps(12);
        drain(60);
        cyc(2);
        sys_rst_n = 1'b0;
        #1;
        chk("async_reset_led", bus.led, 6'b111110);
        chk("async_reset_mode", bus.mode, 2'd0);
        chk("async_reset_tick", bus.step_tick, 1'b0);
        model_reset();
        exp_gap = 0;
        cyc(2);
        sys_rst_n = 1'b1;
        push_steps(1);
        drain(10);
        exp_gap = 4;
        push_steps(2);
        drain(12);

        // Short glitches must not change mode or reload the pattern.
        push_steps(2);
        bus.mode_btn_n = 1'b0; cyc(1);
        bus.mode_btn_n = 1'b1; cyc(1);
        bus.mode_btn_n = 1'b0; cyc(1);
        bus.mode_btn_n = 1'b1; cyc(1);
        bus.mode_btn_n = 1'b0; cyc(1);
        bus.mode_btn_n = 1'b1;
        drain(20);
        chk("glitch_mode", bus.mode, 2'd0);

        // Pause with the step counter at 2, then resume.
        cyc(2);
        bus.pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("pause_led_hold", bus.led, led_of(m_pat));
            chk("pause_no_tick", bus.step_tick, 1'b0);
        end
        bus.pause = 1'b0;
        exp_gap   = 0;
        push_steps(1);
        cyc(1);
        chk("resume_tick_early", bus.step_tick, 1'b0);
        cyc(1);
        chk("resume_tick", bus.step_tick, 1'b1);
        drain(4);
        exp_gap = 4;

        // Walk to COUNT mode, full 6-bit count, then wrap to mode 0.
        press(1'b1);
        push_steps(1);
        drain(10);
        press(1'b1);
        push_steps(1);
        drain(10);
        press(1'b1);
        push_steps(64);
        drain(300);
        chk("count_wrap_led", bus.led, 6'b111111);
        press(1'b1);
        chk("wrap_press_seed", bus.led, 6'b111110);
        push_steps(2);
        drain(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the board LED bank. Replaces the fixed 6-LED rotator. Generic LED count, step period and LED polarity. Four selectable display modes, cycled by a debounced pushbutton, plus a pause input. Sits at top level, driving LED pins directly from sys_clk.

Parameters:
LED_W, 6, number of LEDs (2..32)
CLK_HZ, 27_000_000, sys_clk frequency in Hz
STEP_MS, 500, pattern step period in ms; STEP_CYC = CLK_HZ/1000*STEP_MS (must be >= 2)
DEBOUNCE_MS, 20, button stability window; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS (must be >= 1)
ACTIVE_LOW, 1, 1 = led pin low lights the LED; 0 = high lights it
DIM_LEVEL, 8, PWM on-slots out of 16 (0..16); used only with LED_DIM_EN

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset
mode_btn_n  in  1  raw pushbutton, low = pressed, asynchronous to sys_clk
pause  in  1  synchronous level; high freezes the pattern
led  out  LED_W  LED pins, polarity per ACTIVE_LOW
mode  out  2  current mode
step_tick  out  1  one-cycle pulse in the cycle the pattern advances

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. Reset sets all registers immediately:
  - internal on-pattern pat = 1 (bit0 lit); bounce direction = left; mode = 0
  - step counter = 0; step_tick = 0
  - synchroniser FFs and debounced state = 1; debounce counter = 0
  - led = ~pat if ACTIVE_LOW, else pat. With defaults, led = 6'b111110.
- Reset mid-operation returns to exactly these values, whatever the mode or state.
- Step timer: counter of width clog2(STEP_CYC).
  - Counts 0..STEP_CYC-1 while pause = 0.
  - At STEP_CYC-1 it wraps to 0 and asserts step_tick for that one cycle. pat updates on the same edge.
  - pause = 1: counter and pat hold; step_tick = 0. Counter is not cleared; counting resumes from the held value.
- Button path:
  - 2-FF synchroniser, then debounce. The stable state flips only after the synchronised input differs from it for DB_CYC consecutive cycles. Any agreeing cycle clears the debounce counter.
  - A press event is a stable-state transition 1 -> 0. Release generates no event.
  - Press latency from a clean input edge = 2 + DB_CYC cycles.
- Mode change on press event:
  - mode <= mode+1, wrapping 3 -> 0. Accepted even while pause = 1.
  - pat reloads its seed: modes 0/1/2 seed = 1; mode 3 seed = 0. Direction = left; step counter = 0.
  - A press event coinciding with step wrap: the mode change wins, pat = new seed, and step_tick still pulses.
- Modes (applied on each step):
  - 0 ROTATE_L: pat <= {pat[W-2:0], pat[W-1]}
  - 1 ROTATE_R: pat <= {pat[0], pat[W-1:1]}
  - 2 BOUNCE: one lit bit moves toward MSB while direction = left. Moving into bit W-1 sets direction = right; moving into bit 0 sets direction = left. End bits are visited once per sweep. Sequence for W=6 by bit index: 0,1,2,3,4,5,4,3,2,1,0,1,...
  - 3 COUNT: pat <= pat + 1, modulo 2^LED_W.
- led is registered from pat: polarity-mapped, no extra latency beyond the pat register.

Optional Feature:
LED_DIM_EN:
- Defined: a free-running 4-bit PWM counter runs from reset value 0. A lit bit drives its "on" level only while pwm_cnt < DIM_LEVEL; otherwise it drives "off". DIM_LEVEL = 16 gives fully on; 0 gives always off. Unlit bits are always off.
- Not defined: no PWM logic; lit bits are continuously on and DIM_LEVEL is ignored.
- Either way the step and mode behaviour is identical.

Test Plan:
Bench parameters: LED_W=6, CLK_HZ=1000, STEP_MS=4 (STEP_CYC=4), DEBOUNCE_MS=2 (DB_CYC=2), ACTIVE_LOW=1, LED_DIM_EN undefined.
1. Reset and release, pause=0 -> led=111110 in reset; step_tick every 4th cycle; led 111101, 111011, ..., 011111, then 111110 after 6 ticks.
2. mode_btn_n low for 10 cycles -> mode=1 exactly 4 cycles after the edge; led=111110; next ticks 011111 then 101111. Release produces no mode change.
3. mode=2, 12 ticks -> lit index 0,1,2,3,4,5,4,3,2,1,0,1. Assert sys_rst_n low mid-sweep -> led=111110 and mode=0 immediately.
4. mode_btn_n low for 1 cycle, then a 3-cycle bouncy burst (0,1,0) -> mode unchanged, no pat reload.
5. pause high for 20 cycles after counter=2 -> led constant, step_tick=0 throughout. After release, the next step_tick follows in 2 cycles.
6. mode=3, 64 ticks -> pat walks 0..63 then 0 (led=~pat). A fourth press then gives mode=0, led=111110. Press landing on a wrap cycle -> seed loaded, not seed+1.
